// File: rtl/univ_shift_reg_pkg.sv
// Shared definitions for the universal shift register: mode encoding, FSM states
// and the shift-amount saturation helper.
package univ_shift_pkg;

  localparam logic [2:0] MODE_HOLD = 3'b000;
  localparam logic [2:0] MODE_LOAD = 3'b001;
  localparam logic [2:0] MODE_SHL  = 3'b010;
  localparam logic [2:0] MODE_SHR  = 3'b011;
  localparam logic [2:0] MODE_ROL  = 3'b100;
  localparam logic [2:0] MODE_ROR  = 3'b101;
  localparam logic [2:0] MODE_ASR  = 3'b110;
  localparam logic [2:0] MODE_CLR  = 3'b111;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_e;

  // Rotates are deliberately not reduced modulo width; anything past width just clamps.
  function automatic int unsigned sat_amount(input int unsigned amt, input int unsigned width);
    return (amt > width) ? width : amt;
  endfunction

  function automatic logic is_step_mode(input logic [2:0] m);
    return (m >= MODE_SHL) && (m <= MODE_ASR);
  endfunction

endpackage

// File: rtl/univ_shift_reg_step.sv
// Combinational single-bit step: next register value for one shift/rotate step.
module shift_step_unit
  import univ_shift_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0] q,
  input  logic [2:0]       mode,
  input  logic             sin_l,
  input  logic             sin_r,
  output logic [WIDTH-1:0] q_next
);

  // Select the one-bit step for the requested mode; non-step modes pass q through.
  always_comb begin
    q_next = q;
    case (mode)
      MODE_SHL: q_next = {q[WIDTH-2:0], sin_r};
      MODE_SHR: q_next = {sin_l, q[WIDTH-1:1]};
      MODE_ROL: q_next = {q[WIDTH-2:0], q[WIDTH-1]};
      MODE_ROR: q_next = {q[0], q[WIDTH-1:1]};
      MODE_ASR: q_next = {q[WIDTH-1], q[WIDTH-1:1]};
      default:  q_next = q;
    endcase
  end

endmodule

// File: rtl/univ_shift_reg.sv
// Universal shift register: load/clear/hold in one cycle, multi-bit shifts and
// rotates one bit per clock under a start/busy/done handshake.
module univ_shift_reg
  import univ_shift_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int CNT_W = $clog2(WIDTH + 1)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [2:0]       mode,
  input  logic [CNT_W-1:0] amount,
  input  logic [WIDTH-1:0] d,
  input  logic             sin_r,
  input  logic             sin_l,
  output logic [WIDTH-1:0] q,
  output logic             sout_l,
  output logic             sout_r,
  output logic             busy,
  output logic             done
);

  state_e           state_q, state_d;
  logic [WIDTH-1:0] q_q, q_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [2:0]       mode_q, mode_d;
  logic             done_q, done_d;

  logic [2:0]       step_mode_s;
  logic [WIDTH-1:0] step_next_s;
  logic [CNT_W-1:0] amt_sat_s;

  assign amt_sat_s   = CNT_W'(sat_amount(32'(amount), WIDTH));
  // The first step happens on the start edge, before mode_q has been loaded.
  assign step_mode_s = (state_q == IDLE) ? mode : mode_q;

  shift_step_unit #(.WIDTH(WIDTH)) u_step (
    .q      (q_q),
    .mode   (step_mode_s),
    .sin_l  (sin_l),
    .sin_r  (sin_r),
    .q_next (step_next_s)
  );

  // Next-state, datapath and done-pulse decisions.
  always_comb begin
    state_d = state_q;
    q_d     = q_q;
    cnt_d   = cnt_q;
    mode_d  = mode_q;
    done_d  = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          done_d = 1'b1;
          if (mode == MODE_LOAD) begin
            q_d = d;
          end else if (mode == MODE_CLR) begin
            q_d = {WIDTH{1'b0}};
          end else if (is_step_mode(mode)) begin
            mode_d = mode;
            if (amt_sat_s != {CNT_W{1'b0}}) begin
              q_d = step_next_s;
              if (amt_sat_s != CNT_W'(1)) begin
                cnt_d   = amt_sat_s - CNT_W'(1);
                state_d = RUN;
                done_d  = 1'b0;
              end else begin
                cnt_d = {CNT_W{1'b0}};
              end
            end else begin
              q_d = q_q;
            end
          end else begin
            q_d = q_q;
          end
        end else begin
          done_d = 1'b0;
        end
      end
      RUN: begin
        q_d   = step_next_s;
        cnt_d = cnt_q - CNT_W'(1);
        if (cnt_q == CNT_W'(1)) begin
          state_d = IDLE;
          done_d  = 1'b1;
        end else begin
          state_d = RUN;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State registers; reset aborts any operation without a done pulse.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      q_q     <= {WIDTH{1'b0}};
      cnt_q   <= {CNT_W{1'b0}};
      mode_q  <= MODE_HOLD;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      q_q     <= q_d;
      cnt_q   <= cnt_d;
      mode_q  <= mode_d;
      done_q  <= done_d;
    end
  end

  assign q      = q_q;
  assign sout_l = q_q[WIDTH-1];
  assign sout_r = q_q[0];
  assign busy   = (state_q == RUN);
  assign done   = done_q;

endmodule

// File: tb/tb_univ_shift_reg.sv
// Directed scoreboard bench for univ_shift_reg at WIDTH=8.
module tb_univ_shift_reg;
  import univ_shift_pkg::*;

  localparam int W  = 8;
  localparam int CW = $clog2(W + 1);

  logic          clk = 1'b0;
  logic          reset;
  logic          start;
  logic [2:0]    mode;
  logic [CW-1:0] amount;
  logic [W-1:0]  d;
  logic          sin_r, sin_l;
  logic [W-1:0]  q;
  logic          sout_l, sout_r, busy, done;

  typedef struct {
    string        tag;
    logic [W-1:0] q;
    logic         busy;
    logic         done;
  } exp_t;

  exp_t sb[$];
  int   n_tests = 0;
  int   n_fail  = 0;

  univ_shift_reg #(.WIDTH(W)) dut (
    .clk(clk), .reset(reset), .start(start), .mode(mode), .amount(amount),
    .d(d), .sin_r(sin_r), .sin_l(sin_l), .q(q), .sout_l(sout_l),
    .sout_r(sout_r), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic push(input string tag, input logic [W-1:0] eq, input logic eb, input logic ed);
    exp_t e;
    e.tag = tag; e.q = eq; e.busy = eb; e.done = ed;
    sb.push_back(e);
  endtask

  // One clock edge, then compare the oldest scoreboard entry against the DUT.
  task automatic step();
    exp_t e;
    @(posedge clk);
    #1;
    if (sb.size() == 0) begin
      chk("sb_empty", 32'd1, 32'd0);
    end else begin
      e = sb.pop_front();
      chk({e.tag, "_q"},    32'(q),      32'(e.q));
      chk({e.tag, "_busy"}, 32'(busy),   32'(e.busy));
      chk({e.tag, "_done"}, 32'(done),   32'(e.done));
      chk({e.tag, "_soutl"}, 32'(sout_l), 32'(e.q[W-1]));
      chk({e.tag, "_soutr"}, 32'(sout_r), 32'(e.q[0]));
    end
  endtask

  task automatic do_load(input logic [W-1:0] val);
    start = 1'b1; mode = MODE_LOAD; d = val;
    push("load", val, 1'b0, 1'b1);
    step();
    start = 1'b0; d = 8'h00;
    push("load_idle", val, 1'b0, 1'b0);
    step();
  endtask

  initial begin
    logic [W-1:0] m;
    reset = 1'b0; start = 1'b0; mode = MODE_HOLD; amount = '0;
    d = 8'h00; sin_r = 1'b0; sin_l = 1'b0;

    #22;
    chk("rst_q", 32'(q), 32'h0);
    chk("rst_busy", 32'(busy), 32'h0);
    chk("rst_done", 32'(done), 32'h0);
    @(posedge clk); #1;
    reset = 1'b1;

    // LOAD 0xA5: done for exactly one cycle, never busy
    do_load(8'hA5);

    // SHL by 3 with sin_r=1; a CLR start during busy must be ignored
    sin_r = 1'b1;
    start = 1'b1; mode = MODE_SHL; amount = 4'd3;
    push("shl1", 8'h4B, 1'b1, 1'b0);
    step();
    mode = MODE_CLR; amount = 4'd0;
    push("shl2", 8'h97, 1'b1, 1'b0);
    step();
    start = 1'b0;
    push("shl3", 8'h2F, 1'b0, 1'b1);
    step();
    push("shl_idle", 8'h2F, 1'b0, 1'b0);
    step();
    sin_r = 1'b0;

    // ASR by 2 from 0x90
    do_load(8'h90);
    start = 1'b1; mode = MODE_ASR; amount = 4'd2;
    push("asr1", 8'hC8, 1'b1, 1'b0);
    step();
    start = 1'b0;
    push("asr2", 8'hE4, 1'b0, 1'b1);
    step();

    // SHR by 2 with sin_l=0 from 0x90, LOAD issued in the done cycle
    start = 1'b1; mode = MODE_LOAD; d = 8'h90;
    push("load90", 8'h90, 1'b0, 1'b1);
    step();
    sin_l = 1'b0; mode = MODE_SHR; amount = 4'd2;
    push("shr1", 8'h48, 1'b1, 1'b0);
    step();
    start = 1'b0;
    push("shr2", 8'h24, 1'b0, 1'b1);
    step();

    // ROR by 12 saturates to 8 steps and returns to the start value
    do_load(8'h81);
    start = 1'b1; mode = MODE_ROR; amount = 4'd12;
    m = 8'h81;
    for (int i = 1; i <= W; i++) begin
      m = {m[0], m[W-1:1]};
      push($sformatf("ror%0d", i), m, (i < W), (i == W));
    end
    step();
    start = 1'b0;
    for (int i = 2; i <= W; i++) step();
    chk("ror_final", 32'(q), 32'h81);

    // Shift with amount 0: immediate done, q unchanged
    start = 1'b1; mode = MODE_SHL; amount = 4'd0; sin_r = 1'b1;
    push("amt0", 8'h81, 1'b0, 1'b1);
    step();
    start = 1'b0; sin_r = 1'b0;
    push("amt0_idle", 8'h81, 1'b0, 1'b0);
    step();

    // ROL by 6 from 0x01, aborted by reset after two steps
    do_load(8'h01);
    start = 1'b1; mode = MODE_ROL; amount = 4'd6;
    push("rol1", 8'h02, 1'b1, 1'b0);
    step();
    start = 1'b0;
    push("rol2", 8'h04, 1'b1, 1'b0);
    step();
    #2;
    reset = 1'b0;
    #1;
    chk("abort_q", 32'(q), 32'h0);
    chk("abort_busy", 32'(busy), 32'h0);
    chk("abort_done", 32'(done), 32'h0);
    @(posedge clk); #1;
    reset = 1'b1;
    for (int i = 0; i < 8; i++) begin
      push($sformatf("post_abort%0d", i), 8'h00, 1'b0, 1'b0);
      step();
    end

    chk("sb_drained", 32'(sb.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/univ_shift_reg.md
# univ_shift_reg

Parametrised universal shift register with parallel load, bidirectional logical/arithmetic shift, rotate and clear. Multi-bit shifts run one bit per clock under a start/busy/done handshake. It supersedes the fixed 4-bit parallel-in/parallel-out register in the register library and serves as the general-purpose serialiser/deserialiser and shift datapath for the FlipFlops/Register family.

## Interface
Parameters:
- WIDTH, default 8: register width in bits; must be at least 2.
- CNT_W, default $clog2(WIDTH+1): width of the shift-amount field and the step counter.

Ports:
- clk  in  1  single clock; all state updates on its rising edge.
- reset  in  1  asynchronous, active-low reset. Low clears all state immediately, independent of clk.
- start  in  1  command strobe; sampled only in IDLE.
- mode  in  3  operation, sampled with start:
  - 000 HOLD, 001 LOAD, 010 SHL, 011 SHR
  - 100 ROL, 101 ROR, 110 ASR, 111 CLR
- amount  in  CNT_W  number of single-bit steps for the shift and rotate modes; sampled with start.
- d  in  WIDTH  parallel load data; sampled with start in LOAD.
- sin_r  in  1  serial input entering bit 0 on SHL; sampled live at each step edge.
- sin_l  in  1  serial input entering bit WIDTH-1 on SHR; sampled live at each step edge.
- q  out  WIDTH  register contents.
- sout_l  out  1  equals q[WIDTH-1], combinational from q.
- sout_r  out  1  equals q[0], combinational from q.
- busy  out  1  high while a multi-step operation is in progress (state RUN).
- done  out  1  registered one-cycle pulse in the cycle after the edge that completes a command.

## Operation
Single-step rules:
- SHL: q <= {q[WIDTH-2:0], sin_r}.
- SHR: q <= {sin_l, q[WIDTH-1:1]}.
- ROL: q <= {q[WIDTH-2:0], q[WIDTH-1]}.
- ROR: q <= {q[0], q[WIDTH-1:1]}.
- ASR: q <= {q[WIDTH-1], q[WIDTH-1:1]}.

Amount handling: an effective amount greater than WIDTH saturates to WIDTH. Rotates are not reduced modulo WIDTH, so they still take WIDTH steps.

State machine, states IDLE and RUN:
- IDLE, start=0: q holds, done=0.
- IDLE, start=1 with HOLD, LOAD or CLR: the action takes effect at that edge (LOAD q<=d, CLR q<=0, HOLD no change). State stays IDLE. done=1 next cycle.
- IDLE, start=1 with a shift/rotate mode and amount=0: q unchanged, state stays IDLE, done=1 next cycle.
- IDLE, start=1 with a shift/rotate mode and amount=k≥1: mode is latched and the first step is applied at that edge.
  - k=1: state stays IDLE, done=1 next cycle.
  - k>1: counter <= k-1, state goes to RUN.
- RUN: one step per edge; the counter decrements on each edge. The edge that applies the final step returns the state to IDLE and sets done=1 for the following cycle.
- start while busy is ignored. It is not queued and not an error.
- No abort command; only reset terminates an operation in progress.

## Timing
- Reset values: q=0, busy=0, done=0, state=IDLE, counter=0, latched mode=HOLD.
- Reset asserted mid-operation aborts immediately. After release the block is in IDLE with q=0; no done pulse is generated for the aborted command.
- Latency for amount k (after saturation): q is final after k edges, counting the start edge.
  - busy is high for k-1 cycles.
  - done is high in cycle k+1 relative to the start cycle.
- The earliest next command is the cycle in which done is high; start is accepted there because the state is IDLE.
- sout_l and sout_r have zero added latency from q.

## Structure
- Package univ_shift_pkg holds:
  - the mode encoding constants (MODE_HOLD through MODE_CLR);
  - the state constants IDLE and RUN;
  - the saturation helper for amount.
- Sub-module shift_step_unit: purely combinational, computing the next q from q, the latched mode, sin_l and sin_r. The top level holds the q register, counter, FSM and done register.

## Test plan
All scenarios use WIDTH=8.
- Reset: hold reset low, then release → q=0x00, busy=0, done=0. Reset asserted asynchronously mid-cycle clears q without waiting for a clock edge.
- LOAD with d=0xA5:
  - q=0xA5 after the start edge;
  - done high exactly one cycle;
  - busy never asserts.
- SHL, amount=3, sin_r=1, from q=0xA5:
  - q steps through 0x4B, 0x97, 0x2F;
  - busy high 2 cycles, done high 1 cycle afterwards;
  - a start issued during busy has no effect.
- ASR, amount=2, from q=0x90 → q goes 0xC8, then 0xE4. SHR with sin_l=0 on the same data → 0x48, then 0x24.
- ROR, amount=12, from q=0x81 → saturates to 8 steps: q=0x81 at the end, busy high 7 cycles. A shift with amount=0 gives an immediate done and leaves q unchanged.
- Reset mid-run:
  - start ROL, amount=6, on 0x01;
  - assert reset after 2 steps → q=0x00 and busy=0 immediately;
  - no done pulse follows.
